perf_counter_bank: RTL and testbench
====================================

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 6, meaning number of event channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of every counter (2..64).
REQ-003 SHALL have parameter SATURATE, default 1, meaning 1 = counters hold at max on overflow, 0 = counters wrap to zero.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port event_vec, input, NUM_CH, meaning per-channel event strobe; one count per asserted bit per cycle.
REQ-007 SHALL have port halt, input, 1, meaning the processor halt strobe.
REQ-008 SHALL have port clr, input, 1, meaning synchronous clear of all counters and flags.
REQ-009 SHALL have port rd_req, input, 1, meaning readout request.
REQ-010 SHALL have port rd_sel, input, clog2(NUM_CH+1), meaning readout index.
REQ-011 SHALL have port rd_valid, output, 1, meaning rd_data is valid.
REQ-012 SHALL have port rd_data, output, CNT_W, meaning the registered readout value.
REQ-013 SHALL have port cycle_count, output, CNT_W, meaning the live cycle counter.
REQ-014 SHALL have port halted, output, 1, meaning the bank is frozen after a halt.
REQ-015 SHALL have port ovf, output, NUM_CH+1, meaning sticky overflow flags; bit NUM_CH belongs to the cycle counter.

Function
REQ-016 SHALL implement a two-state FSM: RUN and HALTED.
REQ-017 In RUN, cycle_count SHALL increment by 1 every cycle.
REQ-018 In RUN, channel i SHALL increment by 1 in each cycle in which event_vec[i]=1.
REQ-019 On a halt=1 cycle in RUN, the counts for that cycle SHALL still be applied, the cycle counter included; the FSM SHALL then enter HALTED and halted SHALL assert on the following cycle.
REQ-020 In HALTED, all counters and ovf SHALL hold regardless of event_vec and halt.
REQ-021 The FSM SHALL leave HALTED only via clr or rst.
REQ-022 clr=1 SHALL, on the next edge, zero all counters, cycle_count and ovf, and enter RUN.
REQ-023 clr SHALL take priority over events and halt in the same cycle: nothing is counted and the FSM does not enter HALTED.
REQ-024 Overflow with SATURATE=1: a counter at 2^CNT_W-1 receiving an increment SHALL stay at 2^CNT_W-1 and set its ovf bit.
REQ-025 Overflow with SATURATE=0: a counter at 2^CNT_W-1 receiving an increment SHALL become 0 and set its ovf bit.
REQ-026 ovf bits SHALL be sticky until clr or rst.
REQ-027 Readout SHALL have 1-cycle latency: rd_req=1 at edge N gives rd_valid=1 after edge N, with rd_data holding the counter value sampled before the edge-N update.
REQ-028 Readout index SHALL map as follows:
- rd_sel < NUM_CH: channel counter.
- rd_sel = NUM_CH: cycle counter.
- rd_sel > NUM_CH: rd_data = 0 with rd_valid still asserted.
REQ-029 Back-to-back rd_req SHALL be accepted every cycle, one response per request, in order.
REQ-030 rd_valid SHALL deassert the cycle after a cycle with rd_req=0.
REQ-031 Readout SHALL be serviced in both RUN and HALTED, and SHALL not be affected by a simultaneous clr; it returns the pre-clear value.
REQ-032 Counting SHALL be exact: no event lost and no double count.

Reset
REQ-033 While rst=0, regardless of clk, all of the following SHALL hold:
- all counters and cycle_count = 0
- ovf = 0
- rd_valid = 0
- rd_data = 0
- halted = 0
- FSM = RUN
REQ-034 Reset asserted mid-operation, including in HALTED or during a readout, SHALL abort everything with no pending response after release.
REQ-035 Counting SHALL resume on the first rising edge after rst returns to 1.

Verification
REQ-036 Scenario basic count: release reset, pulse event_vec[2] on 5 of 10 cycles, then rd_req with rd_sel=2 -> rd_data=5, and rd_sel=NUM_CH -> value equals cycle_count at request.
REQ-037 Scenario halt freeze: halt together with event_vec[0] at cycle 7 -> channel 0 includes that event, halted=1 next cycle, and all counters unchanged over 20 further cycles of random events.
REQ-038 Scenario overflow (CNT_W=4):
- SATURATE=1: 17 events on channel 1 -> count=15, ovf[1]=1.
- SATURATE=0: 17 events -> count=1, ovf[1]=1.
REQ-039 Scenario clr priority: clr with halt and all events in the same cycle -> next cycle all counters=0, ovf=0, halted=0, then counting resumes.
REQ-040 Scenario readout streaming: rd_req held 4 cycles with rd_sel=0,1,NUM_CH,NUM_CH+1 -> 4 consecutive rd_valid cycles with the matching values, the last being 0.
REQ-041 Scenario async reset: drop rst between clock edges while HALTED with rd_req active -> outputs zero immediately, and no rd_valid after release.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Performance counter bank: per-channel event counters plus a cycle counter,
// with halt freeze, synchronous clear, sticky overflow and registered readout.
module perf_counter_bank #(
    parameter int NUM_CH   = 6,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 1,
    localparam int SEL_W   = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] event_vec,
    input  logic              halt,
    input  logic              clr,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [CNT_W-1:0]  cycle_count,
    output logic              halted,
    output logic [NUM_CH:0]   ovf
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [NUM_CH+1];
    logic [CNT_W-1:0]   cnt_d [NUM_CH+1];
    logic [NUM_CH:0]    ovf_q, ovf_d;
    logic [NUM_CH:0]    inc;
    logic               rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]   rd_data_q, rd_data_d;

    // Slot NUM_CH is the cycle counter, which counts every RUN cycle.
    assign inc = {1'b1, event_vec};

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = RUN;
        end else begin
            unique case (state_q)
                RUN:     if (halt) state_d = HALTED;
                HALTED:  state_d = HALTED;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i <= NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (state_q == RUN && inc[i]) begin
                if (cnt_q[i] == MAX) begin
                    cnt_d[i] = (SATURATE != 0) ? MAX : '0;
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Readout samples pre-update values, so a simultaneous clr returns old data.
    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = rd_data_q;
        if (rd_req) begin
            rd_data_d = '0;
            for (int i = 0; i <= NUM_CH; i++) begin
                if (rd_sel == SEL_W'(i)) rd_data_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            ovf_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i <= NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            ovf_q      <= ovf_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            for (int i = 0; i <= NUM_CH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign cycle_count = cnt_q[NUM_CH];
    assign halted      = (state_q == HALTED);
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: one 16-bit bank and two 4-bit banks
// (saturating and wrapping) for the overflow cases.
module tb_perf_counter_bank;

    localparam int NCH = 6;

    logic        clk;
    logic        rst;
    logic [5:0]  event_vec;
    logic        halt;
    logic        clr;
    logic        rd_req;
    logic [2:0]  rd_sel;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [15:0] cycle_count;
    logic        halted;
    logic [6:0]  ovf;

    logic [5:0]  o_ev;
    logic        o_clr;
    logic        o_rd_req;
    logic [2:0]  o_rd_sel;
    logic        s_rd_valid, w_rd_valid;
    logic [3:0]  s_rd_data, w_rd_data;
    logic [3:0]  s_cyc, w_cyc;
    logic        s_halted, w_halted;
    logic [6:0]  s_ovf, w_ovf;

    int checks;
    int errors;

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(16), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .event_vec(event_vec), .halt(halt),
        .clr(clr), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .cycle_count(cycle_count), .halted(halted), .ovf(ovf)
    );

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .event_vec(o_ev), .halt(1'b0),
        .clr(o_clr), .rd_req(o_rd_req), .rd_sel(o_rd_sel),
        .rd_valid(s_rd_valid), .rd_data(s_rd_data),
        .cycle_count(s_cyc), .halted(s_halted), .ovf(s_ovf)
    );

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .event_vec(o_ev), .halt(1'b0),
        .clr(o_clr), .rd_req(o_rd_req), .rd_sel(o_rd_sel),
        .rd_valid(w_rd_valid), .rd_data(w_rd_data),
        .cycle_count(w_cyc), .halted(w_halted), .ovf(w_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        event_vec = '0;
        halt      = 1'b0;
        clr       = 1'b0;
        rd_req    = 1'b0;
        rd_sel    = '0;
        o_ev      = '0;
        o_clr     = 1'b0;
        o_rd_req  = 1'b0;
        o_rd_sel  = '0;

        #3;
        check("rst_cyc", 64'(cycle_count), 64'd0);
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);

        event_vec = 6'h3f;
        halt      = 1'b1;
        rd_req    = 1'b1;
        tick();
        tick();
        check("rst_hold_cyc", 64'(cycle_count), 64'd0);
        check("rst_hold_valid", 64'(rd_valid), 64'd0);
        check("rst_hold_halted", 64'(halted), 64'd0);
        event_vec = '0;
        halt      = 1'b0;
        rd_req    = 1'b0;

        @(negedge clk);
        rst = 1'b1;

        // Basic count: ch2 on 5 of 10 cycles.
        for (int i = 0; i < 10; i++) begin
            event_vec = (i % 2 == 0) ? 6'b000100 : 6'b000000;
            tick();
        end
        event_vec = '0;
        check("basic_cyc", 64'(cycle_count), 64'd10);
        rd_req = 1'b1;
        rd_sel = 3'd2;
        tick();
        check("basic_rd_valid", 64'(rd_valid), 64'd1);
        check("basic_rd_ch2", 64'(rd_data), 64'd5);
        rd_sel = 3'(NCH);
        tick();
        check("basic_rd_cyc", 64'(rd_data), 64'd11);
        check("basic_cyc_live", 64'(cycle_count), 64'd12);
        rd_req = 1'b0;
        tick();
        check("basic_rd_drop", 64'(rd_valid), 64'd0);

        // Halt freeze.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cyc", 64'(cycle_count), 64'd0);
        for (int i = 0; i < 6; i++) tick();
        event_vec = 6'b000001;
        halt      = 1'b1;
        tick();
        check("halt_asserted", 64'(halted), 64'd1);
        check("halt_cyc", 64'(cycle_count), 64'd7);
        halt = 1'b0;
        for (int i = 0; i < 20; i++) begin
            event_vec = 6'($urandom);
            halt      = 1'($urandom);
            tick();
        end
        event_vec = '0;
        halt      = 1'b0;
        check("freeze_cyc", 64'(cycle_count), 64'd7);
        check("freeze_halted", 64'(halted), 64'd1);
        check("freeze_ovf", 64'(ovf), 64'd0);
        rd_req = 1'b1;
        rd_sel = 3'd0;
        tick();
        check("freeze_rd_ch0", 64'(rd_data), 64'd1);
        rd_sel = 3'd2;
        tick();
        check("freeze_rd_ch2", 64'(rd_data), 64'd0);

        // Clear with halt, all events and a readout in the same cycle.
        rd_sel    = 3'd0;
        clr       = 1'b1;
        halt      = 1'b1;
        event_vec = 6'h3f;
        tick();
        check("clrp_rd_old", 64'(rd_data), 64'd1);
        check("clrp_cyc", 64'(cycle_count), 64'd0);
        check("clrp_halted", 64'(halted), 64'd0);
        check("clrp_ovf", 64'(ovf), 64'd0);
        clr       = 1'b0;
        halt      = 1'b0;
        rd_req    = 1'b0;
        event_vec = 6'b000001;
        tick();
        tick();
        tick();
        event_vec = '0;
        rd_req    = 1'b1;
        rd_sel    = 3'd0;
        tick();
        check("resume_ch0", 64'(rd_data), 64'd3);
        check("resume_cyc", 64'(cycle_count), 64'd4);
        rd_req    = 1'b0;
        event_vec = 6'b000010;
        tick();
        tick();
        event_vec = '0;

        // Streaming readout.
        rd_req = 1'b1;
        rd_sel = 3'd0;
        tick();
        check("strm0_valid", 64'(rd_valid), 64'd1);
        check("strm0_data", 64'(rd_data), 64'd3);
        rd_sel = 3'd1;
        tick();
        check("strm1_valid", 64'(rd_valid), 64'd1);
        check("strm1_data", 64'(rd_data), 64'd2);
        rd_sel = 3'(NCH);
        tick();
        check("strm2_valid", 64'(rd_valid), 64'd1);
        check("strm2_data", 64'(rd_data), 64'd8);
        rd_sel = 3'(NCH + 1);
        tick();
        check("strm3_valid", 64'(rd_valid), 64'd1);
        check("strm3_data", 64'(rd_data), 64'd0);
        rd_req = 1'b0;
        tick();
        check("strm_end", 64'(rd_valid), 64'd0);

        // Overflow on 4-bit banks.
        o_clr = 1'b1;
        tick();
        o_clr = 1'b0;
        check("ov_clr", 64'(s_ovf), 64'd0);
        o_ev = 6'b000010;
        for (int i = 0; i < 17; i++) tick();
        o_ev     = '0;
        o_rd_req = 1'b1;
        o_rd_sel = 3'd1;
        tick();
        o_rd_req = 1'b0;
        check("sat_cnt", 64'(s_rd_data), 64'd15);
        check("wrap_cnt", 64'(w_rd_data), 64'd1);
        check("sat_cyc", 64'(s_cyc), 64'd15);
        check("sat_ovf", 64'(s_ovf), 64'b1000010);
        check("wrap_ovf", 64'(w_ovf), 64'b1000010);
        tick();
        check("wrap_ovf_sticky", 64'(w_ovf), 64'b1000010);

        // Async reset while halted with a readout in flight.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("ar_halted", 64'(halted), 64'd1);
        rd_req = 1'b1;
        rd_sel = 3'(NCH);
        tick();
        check("ar_valid_pre", 64'(rd_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", 64'(rd_valid), 64'd0);
        check("ar_data", 64'(rd_data), 64'd0);
        check("ar_halted0", 64'(halted), 64'd0);
        check("ar_cyc", 64'(cycle_count), 64'd0);
        check("ar_sat_ovf", 64'(s_ovf), 64'd0);
        rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("ar_no_resp", 64'(rd_valid), 64'd0);
        check("ar_resume", 64'(cycle_count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
